// File: rtl/spi_burst_arb_pkg.sv
// Shared definitions for the SPI burst arbiter: FSM encoding, command-byte
// layout and field widths.
package spi_burst_arb_pkg;

   localparam int ADDR_W     = 7;
   localparam int LEN_W      = 4;
   localparam int CMD_RD_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_CMD,
      ST_DATA,
      ST_GAP,
      ST_FIN,
      ST_ABORT
   } state_t;

   function automatic logic [7:0] cmd_byte(input logic rw, input logic [ADDR_W-1:0] addr);
      logic [7:0] b;
      b = {1'b0, addr};
      b[CMD_RD_BIT] = rw;
      return b;
   endfunction

   function automatic logic [1:0] one_hot2(input logic idx);
      return {idx, ~idx};
   endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the client granted last
// and is only moved when the owning transaction finishes.
module spi_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic [1:0] gnt
);

   logic last_q;

   // Reset pretends client 1 went last so client 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (upd) begin
         last_q <= upd_idx;
      end
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/spi_burst_arb.sv
// Arbitrates two clients onto one SPI byte engine and sequences a command
// byte followed by Len data bytes, with inter-byte gaps and a per-byte timeout.
module spi_burst_arb
   import spi_burst_arb_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYC = 16'd2048,
   parameter logic [3:0]  GAP_CYC     = 4'd1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  Req,
   input  logic [1:0]  Rw,
   input  logic [13:0] Addr,
   input  logic [7:0]  Len,
   input  logic [15:0] Wdat,
   output logic [1:0]  Wack,
   output logic [7:0]  Rdat,
   output logic [1:0]  Rvld,
   output logic [1:0]  Gnt,
   output logic [1:0]  Done,
   output logic [1:0]  Err,
   output logic        SPI_En,
   output logic [7:0]  SPI_Sbuf,
   input  logic [7:0]  SPI_Rbuf,
   input  logic        SPI_Dat_Rdy,
   input  logic        SPI_Rdy
);

   state_t            state_q, state_d;
   logic              cur_q;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [7:0]        dat_q;
   logic [15:0]       tmo_q;
   logic [3:0]        gap_q;
   logic [1:0]        arb_gnt;
   logic              busy_io;
   logic              ending;
   logic              tmo_hit;

   assign busy_io = (state_q == ST_CMD) || (state_q == ST_DATA);
   assign ending  = (state_q == ST_FIN) || (state_q == ST_ABORT);
   assign tmo_hit = (tmo_q == TIMEOUT_CYC - 16'd1);

   spi_rr_arb2 u_arb (
      .clk     (CLK),
      .rst     (RST),
      .req     (Req),
      .upd     (ending),
      .upd_idx (cur_q),
      .gnt     (arb_gnt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if ((|Req) && SPI_Rdy) state_d = ST_ARB;
         ST_ARB:   state_d = ST_CMD;
         ST_CMD: begin
            if (SPI_Dat_Rdy)  state_d = (cnt_q != '0) ? ST_GAP : ST_FIN;
            else if (tmo_hit) state_d = ST_ABORT;
         end
         ST_GAP:   if (gap_q == GAP_CYC - 4'd1) state_d = ST_DATA;
         ST_DATA: begin
            if (SPI_Dat_Rdy)  state_d = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_GAP;
            else if (tmo_hit) state_d = ST_ABORT;
         end
         ST_FIN:   state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cur_q   <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         dat_q   <= 8'h00;
         tmo_q   <= 16'd0;
         gap_q   <= 4'd0;
         Gnt     <= 2'b00;
         Wack    <= 2'b00;
         Rvld    <= 2'b00;
         Rdat    <= 8'h00;
      end else begin
         state_q <= state_d;
         Wack    <= 2'b00;
         Rvld    <= 2'b00;
         // Both counters restart whenever their state is (re)entered.
         tmo_q   <= busy_io ? tmo_q + 16'd1 : 16'd0;
         gap_q   <= (state_q == ST_GAP) ? gap_q + 4'd1 : 4'd0;
         if (state_q == ST_IDLE && state_d == ST_ARB) begin
            Gnt   <= arb_gnt;
            cur_q <= arb_gnt[1];
         end
         if (state_q == ST_ARB) begin
            rw_q   <= cur_q ? Rw[1] : Rw[0];
            addr_q <= cur_q ? Addr[13:7] : Addr[6:0];
            cnt_q  <= cur_q ? Len[7:4] : Len[3:0];
         end
         if (state_q == ST_GAP && state_d == ST_DATA) begin
            dat_q <= rw_q ? 8'h00 : (cur_q ? Wdat[15:8] : Wdat[7:0]);
            if (!rw_q) Wack <= one_hot2(cur_q);
         end
         if (state_q == ST_DATA && SPI_Dat_Rdy) begin
            cnt_q <= cnt_q - 1'b1;
            if (rw_q) begin
               Rdat <= SPI_Rbuf;
               Rvld <= one_hot2(cur_q);
            end
         end
         if (state_d == ST_FIN || state_d == ST_ABORT) Gnt <= 2'b00;
      end
   end

   always_comb begin
      SPI_En   = busy_io;
      SPI_Sbuf = 8'h00;
      if (state_q == ST_CMD)       SPI_Sbuf = cmd_byte(rw_q, addr_q);
      else if (state_q == ST_DATA) SPI_Sbuf = dat_q;
   end

   assign Done = (state_q == ST_FIN)   ? one_hot2(cur_q) : 2'b00;
   assign Err  = (state_q == ST_ABORT) ? one_hot2(cur_q) : 2'b00;

endmodule

// File: doc/spi_burst_arb.md
SPI_BURST_ARB -- requirements
Module: spi_burst_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, 16'd2048, maximum CLK cycles to wait for SPI_Dat_Rdy per byte before aborting.
REQ-002 Parameter GAP_CYC, 4'd1, idle cycles with SPI_En low between consecutive bytes (legal range 1..15).
REQ-003 CLK  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 Req  in  2  per-client transfer request, bit i is client i, held high until Done[i] or Err[i].
REQ-006 Rw  in  2  per-client direction: 1 = read, 0 = write.
REQ-007 Addr  in  14  per-client 7-bit register address, client i on bits [7i+6:7i].
REQ-008 Len  in  8  per-client data byte count 0..15, client i on bits [4i+3:4i].
REQ-009 Wdat  in  16  per-client write data byte, client i on bits [8i+7:8i].
REQ-010 Wack  out  2  one-cycle pulse: the current Wdat byte of client i has been consumed.
REQ-011 Rdat  out  8  read data byte, shared by both clients.
REQ-012 Rvld  out  2  one-cycle pulse: Rdat is valid for client i.
REQ-013 Gnt  out  2  one-hot grant, high for the whole transaction.
REQ-014 Done  out  2  one-cycle pulse at normal completion.
REQ-015 Err  out  2  one-cycle pulse at timeout abort.
REQ-016 SPI_En  out  1  byte-engine enable, held high for exactly one byte.
REQ-017 SPI_Sbuf  out  8  byte to transmit, stable while SPI_En is high.
REQ-018 SPI_Rbuf  in  8  received byte, valid when SPI_Dat_Rdy is high.
REQ-019 SPI_Dat_Rdy  in  1  one-cycle pulse from the engine: byte complete.
REQ-020 SPI_Rdy  in  1  high when the engine is initialised; no grant is issued while it is low.

Function
REQ-021 The FSM shall have the states IDLE, ARB, CMD, DATA, GAP, FIN and ABORT.
REQ-022 IDLE: when (|Req) && SPI_Rdy, go to ARB; the request vector is sampled only in IDLE.
REQ-023 ARB: assert a one-hot Gnt using round-robin, preferring the client not granted last; both clients requesting with the pointer at reset selects client 0.
REQ-024 ARB: latch Rw, Addr and Len of the granted client, then go to CMD, so Gnt rises 1 cycle after Req is seen in IDLE.
REQ-025 CMD: drive SPI_Sbuf={Rw,Addr} and SPI_En=1, and wait for SPI_Dat_Rdy.
REQ-026 On SPI_Dat_Rdy in CMD: discard SPI_Rbuf, drop SPI_En, go to GAP if latched Len!=0, otherwise go to FIN.
REQ-027 GAP: hold SPI_En=0 for GAP_CYC cycles, then go to DATA.
REQ-028 DATA write: on entry, load SPI_Sbuf from the granted Wdat and pulse Wack for 1 cycle; the client shall present the next byte by the following cycle.
REQ-029 DATA read: SPI_Sbuf=8'h00.
REQ-030 DATA: on SPI_Dat_Rdy of a read, register Rdat=SPI_Rbuf and pulse Rvld of the granted client on the next cycle.
REQ-031 DATA: decrement a 4-bit remaining-byte counter on each SPI_Dat_Rdy; at 0 go to FIN, otherwise go to GAP.
REQ-032 FIN: pulse Done, clear Gnt, update the round-robin pointer, and return to IDLE.
REQ-033 Timeout: a 16-bit counter cleared on each SPI_En rising edge counts while waiting in CMD or DATA; reaching TIMEOUT_CYC goes to ABORT.
REQ-034 ABORT: drop SPI_En, pulse Err, clear Gnt, update the pointer, and return to IDLE; no Done is issued.
REQ-035 Client deassertion of Req mid-transaction shall be ignored; a transaction always runs to FIN or ABORT.
REQ-036 SPI_Dat_Rdy outside CMD or DATA shall be ignored.
REQ-037 Total Wack pulses shall equal Len for a write, and total Rvld pulses shall equal Len for a read.
REQ-038 Len=0 shall send the command byte only.

Reset
REQ-039 RST, including mid-transaction, shall return the FSM to IDLE in the next cycle.
REQ-040 Reset values: SPI_En=0, SPI_Sbuf=8'h00, Rdat=8'h00, Gnt=Wack=Rvld=Done=Err=0.
REQ-041 Reset clears the timeout and byte counters and sets the pointer to favour client 0.

Structure
REQ-042 A shared package shall hold the FSM state encoding, the command-byte read bit position (7), and the widths ADDR_W=7 and LEN_W=4.
REQ-043 One sub-module, spi_rr_arb2 (2-way round-robin arbiter with pointer update input), shall be instantiated.

Verification
REQ-044 Client 0 write, Addr=7'h1A, Len=2, Wdat 8'h55 then 8'hAA -> SPI_Sbuf sequence 8'h1A, 8'h55, 8'hAA; 2 Wack pulses; Done[0] once.
REQ-045 Client 1 read, Addr=7'h3B, Len=3, engine returns 8'h11, 8'h22, 8'h33 -> command byte 8'hBB; Rdat 8'h11/8'h22/8'h33 with 3 Rvld[1] pulses; Done[1].
REQ-046 Both Req high in the same cycle, three back-to-back rounds -> grant order client 0, client 1, client 0.
REQ-047 Len=0 read, Addr=7'h75 -> a single byte 8'hF5, no Rvld, Done pulse.
REQ-048 TIMEOUT_CYC=16'd16, engine never pulses SPI_Dat_Rdy -> Err pulse 16 cycles after SPI_En rises, no Done, Gnt cleared, SPI_En low.
REQ-049 RST asserted in the 2nd data byte of a Len=4 write -> all outputs at reset values the next cycle; a new request then completes normally.
